hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 24 ++
 rtl/hazard_scoreboard_sb_entry.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 87 ++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Purpose  : Constants shared by the hazard scoreboard and its per-register
//            entries: register file geometry, pending-count width, and the
//            count loaded on issue for each forwarding configuration.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

   localparam int REG_COUNT  = 16;
   localparam int REG_ADDR_W = 4;
   localparam int PC_W       = 2;
   localparam int STALL_W    = 16;

   // Cycles until a result can be read in ID without forwarding (write
   // happens in WB, visible in ID that same cycle).
   localparam logic [PC_W-1:0] ISSUE_CNT_NOFWD = 2'd2;

   // With forwarding only a load result is late, by exactly one cycle.
   localparam logic [PC_W-1:0] ISSUE_CNT_FWD   = 2'd1;

endpackage : hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_sb_entry.sv
`default_nettype none
// ============================================================================
// Module   : sb_entry
// Purpose  : Scoreboard state of one architectural register: pending count
//            with load / decrement / hold, plus the flag recording whether
//            the youngest pending writer is a load.
// Revision : 1.0 - initial release
// ============================================================================
module sb_entry
   import hazard_scoreboard_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            freeze,
   input  logic            load,
   input  logic [PC_W-1:0] load_cnt,
   input  logic            load_ld,
   output logic [PC_W-1:0] pc,
   output logic            ld
);

   logic [PC_W-1:0] r_pc;
   logic            r_ld;

   // Youngest writer overwrites; otherwise count down toward "safe", all held on freeze.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= '0;
         r_ld <= 1'b0;
      end else if (!freeze) begin
         if (load) begin
            r_pc <= load_cnt;
            r_ld <= load_ld;
         end else if (r_pc != '0) begin
            r_pc <= r_pc - PC_W'(1);
         end
      end
   end

   assign pc = r_pc;
   assign ld = r_ld;

endmodule : sb_entry
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Per-register pending-write scoreboard producing the IF/ID stall
//            request, a busy mask and a saturating stall-cycle counter.
//            Build option: define HAZARD_FORWARDING_EN to track only loads
//            (one-cycle load-use stall); otherwise every writer blocks its
//            destination for two cycles.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic                  id_WB_EN,
   input  logic                  id_MEM_R_EN,
   input  logic [REG_ADDR_W-1:0] id_Dest,
   input  logic [REG_ADDR_W-1:0] src1,
   input  logic [REG_ADDR_W-1:0] src2,
   input  logic                  use_src1,
   input  logic                  Two_src,
   output logic                  hazard,
   output logic [REG_COUNT-1:0]  busy_mask,
   output logic [STALL_W-1:0]    stall_cnt
);

   logic [PC_W-1:0]      w_pc [REG_COUNT];
   logic [REG_COUNT-1:0] w_ld;
   logic [REG_COUNT-1:0] w_busy;
   logic                 w_hazard;
   logic                 w_issue;
   logic                 w_track;
   logic [PC_W-1:0]      w_issue_cnt;
   logic [STALL_W-1:0]   r_stall_cnt;

`ifdef HAZARD_FORWARDING_EN
   // Only loads are late enough to need a scoreboard entry.
   assign w_track     = id_MEM_R_EN;
   assign w_issue_cnt = ISSUE_CNT_FWD;
   assign w_hazard    = (use_src1 && w_busy[src1] && w_ld[src1]) ||
                        (Two_src  && w_busy[src2] && w_ld[src2]);
`else
   // Every writer is tracked until its WB; the load flag carries no meaning here.
   logic w_unused_ld;
   assign w_unused_ld = ^w_ld;
   assign w_track     = 1'b1;
   assign w_issue_cnt = ISSUE_CNT_NOFWD;
   assign w_hazard    = (use_src1 && w_busy[src1]) ||
                        (Two_src  && w_busy[src2]);
`endif

   assign w_issue = id_WB_EN && !w_hazard && !freeze && !flush;

   generate
      for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_entry
         sb_entry u_entry (
            .clk      (clk),
            .rst      (rst),
            .freeze   (freeze),
            .load     (w_issue && w_track && (id_Dest == REG_ADDR_W'(gi))),
            .load_cnt (w_issue_cnt),
            .load_ld  (id_MEM_R_EN),
            .pc       (w_pc[gi]),
            .ld       (w_ld[gi])
         );
         assign w_busy[gi] = (w_pc[gi] != '0);
      end
   endgenerate

   // Count cycles the front end actually spends stalled, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (!freeze && w_hazard && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
   end

   assign hazard    = w_hazard;
   assign busy_mask = w_busy;
   assign stall_cnt = r_stall_cnt;

endmodule : hazard_scoreboard
`default_nettype wire
